// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// CLK runs at PRESCALE times the bit rate. A frame is a start bit, DATA_WIDTH
// data bits (LSB first), an optional parity bit and a stop bit. Each bit is
// decided by a 3-sample majority vote taken around the bit centre, so a single
// corrupted sample does not change the result.
//
// Output protocol: DATA_VALID is a one-cycle pulse with no ready/backpressure.
// P_DATA changes only in the cycle DATA_VALID is high and otherwise holds the
// last good word. PAR_ERR and STP_ERR describe the most recent frame and stay
// set until the next start bit is detected.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic [2:0]            dbg_state_o
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0]         LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                  state_q;
  logic                    sync1_q;
  logic                    sync2_q;
  logic [PRESCALE_W-1:0]   edge_q;
  logic [BW-1:0]           bit_q;
  logic [PRESCALE_W-1:0]   presc_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic                    samp0_q;
  logic                    samp1_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [DATA_WIDTH-1:0]   p_data_q;
  logic                    valid_q;
  logic                    par_err_q;
  logic                    stp_err_q;

  logic                    rx_s;
  logic [PRESCALE_W-1:0]   half_d;
  logic                    at_lo;
  logic                    at_mid;
  logic                    at_hi;
  logic                    at_last;
  logic                    vote;
  logic                    exp_par;
  logic [PRESCALE_W-1:0]   edge_inc_d;

  assign rx_s = sync2_q;

  // Sample-point decode relative to the prescale latched at start detection,
  // plus the majority vote formed from the two earlier samples and the current one.
  always_comb begin
    half_d     = presc_q >> 1;
    at_lo      = (edge_q == (half_d - ONE));
    at_mid     = (edge_q == half_d);
    at_hi      = (edge_q == (half_d + ONE));
    at_last    = (edge_q == (presc_q - ONE));
    vote       = (samp0_q & samp1_q) | (samp0_q & rx_s) | (samp1_q & rx_s);
    exp_par    = (^shift_q) ^ par_typ_q;
    edge_inc_d = edge_q + ONE;
  end

  // Frame FSM with synchronizer, counters, sample capture and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      edge_q    <= '0;
      bit_q     <= '0;
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      samp0_q   <= 1'b1;
      samp1_q   <= 1'b1;
      shift_q   <= '0;
      p_data_q  <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else begin
      sync1_q <= RX_IN;
      sync2_q <= sync1_q;
      valid_q <= 1'b0;

      if (state_q != S_IDLE) begin
        if (at_lo)  samp0_q <= rx_s;
        if (at_mid) samp1_q <= rx_s;
      end

      case (state_q)
        S_IDLE: begin
          edge_q <= '0;
          bit_q  <= '0;
          if (!rx_s) begin
            // This cycle is edge 0 of the start bit; frame options are frozen here.
            state_q   <= S_START;
            edge_q    <= ONE;
            presc_q   <= PRESCALE;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
          end
        end

        S_START: begin
          if (at_hi && vote) begin
            // Start bit did not hold low through its centre: treat as a glitch.
            state_q <= S_IDLE;
            edge_q  <= '0;
          end else if (at_last) begin
            state_q <= S_DATA;
            edge_q  <= '0;
          end else begin
            edge_q <= edge_inc_d;
          end
        end

        S_DATA: begin
          if (at_hi) shift_q[bit_q] <= vote;
          if (at_last) begin
            edge_q <= '0;
            if (bit_q == LAST_BIT) begin
              bit_q   <= '0;
              state_q <= par_en_q ? S_PARITY : S_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            edge_q <= edge_inc_d;
          end
        end

        S_PARITY: begin
          if (at_hi && (vote != exp_par)) par_err_q <= 1'b1;
          if (at_last) begin
            state_q <= S_STOP;
            edge_q  <= '0;
          end else begin
            edge_q <= edge_inc_d;
          end
        end

        S_STOP: begin
          // The stop bit ends at its decision point; the counter is allowed to
          // wrap freely so an odd prescale cannot skip the decision and stall.
          if (at_hi) begin
            state_q   <= S_IDLE;
            edge_q    <= '0;
            stp_err_q <= ~vote;
            if (!par_err_q && vote) begin
              p_data_q <= shift_q;
              valid_q  <= 1'b1;
            end
          end else begin
            edge_q <= edge_inc_d;
          end
        end

        default: begin
          state_q <= S_IDLE;
          edge_q  <= '0;
        end
      endcase
    end
  end

  assign P_DATA      = p_data_q;
  assign DATA_VALID  = valid_q;
  assign PAR_ERR     = par_err_q;
  assign STP_ERR     = stp_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a frame-level reference
// model (expected word / parity / stop outcome computed from the frame fields).
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] PRESCALE;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;
  logic [2:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .PRESCALE(PRESCALE), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR), .dbg_state_o(dbg_state)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  // Output monitor, sampled on the falling edge: counts valid pulses, records
  // delivered words and counts rising edges of the two error flags.
  int         vcnt    = 0;
  int         par_cnt = 0;
  int         stp_cnt = 0;
  logic       par_prev = 1'b0;
  logic       stp_prev = 1'b0;
  logic [7:0] got_q[$];

  always @(negedge CLK) begin
    if (DATA_VALID === 1'b1) begin
      vcnt++;
      got_q.push_back(P_DATA);
    end
    if (PAR_ERR === 1'b1 && !par_prev) par_cnt++;
    if (STP_ERR === 1'b1 && !stp_prev) stp_cnt++;
    par_prev = (PAR_ERR === 1'b1);
    stp_prev = (STP_ERR === 1'b1);
  end

  // Scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int v0, p0, s0;

  // Driver tasks
  task automatic snap();
    v0 = vcnt; p0 = par_cnt; s0 = stp_cnt;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive_bit(input logic v, input int p, input int glitch);
    for (int c = 0; c < p; c++) begin
      RX_IN = (c == glitch) ? ~v : v;
      @(negedge CLK);
    end
  endtask

  // gbit: frame position to glitch for one cycle at mid-bit (0 = start, 1..8 = data), -1 none
  task automatic send_frame(input logic [7:0] d, input int p, input bit pen,
                            input bit pbit, input bit sbit, input int gbit);
    drive_bit(1'b0, p, (gbit == 0) ? p / 2 : -1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p, (gbit == i + 1) ? p / 2 : -1);
    if (pen) drive_bit(pbit, p, -1);
    drive_bit(sbit, p, -1);
    RX_IN = 1'b1;
  endtask

  task automatic config_rx(input int p, input bit pen, input bit typ);
    PRESCALE = 6'(p); PAR_EN = pen; PAR_TYP = typ;
  endtask

  task automatic test_reset();
    RST = 1'b1; RX_IN = 1'b1;
    config_rx(8, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    n_tests++;
    if (P_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_p_data: got %h exp 00", P_DATA); end
    n_tests++;
    if (DATA_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", DATA_VALID); end
    n_tests++;
    if ({PAR_ERR, STP_ERR} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b exp 00", {PAR_ERR, STP_ERR}); end
    RST = 1'b0;
    idle(10);
  endtask

  task automatic test_parity_ok();
    config_rx(8, 1'b1, 1'b0);
    snap();
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, -1);
    idle(24);
    last_good = 8'hA5;
    n_tests++;
    if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL par_ok_pulses: got %0d exp 1", vcnt - v0); end
    else begin
      n_tests++;
      if (got_q[v0] !== 8'hA5) begin n_fail++; $display("FAIL par_ok_word: got %h exp a5", got_q[v0]); end
    end
    n_tests++;
    if (P_DATA !== 8'hA5) begin n_fail++; $display("FAIL par_ok_p_data: got %h exp a5", P_DATA); end
    n_tests++;
    if ({PAR_ERR, STP_ERR} !== 2'b00) begin n_fail++; $display("FAIL par_ok_flags: got %b exp 00", {PAR_ERR, STP_ERR}); end
  endtask

  task automatic test_parity_err();
    config_rx(8, 1'b1, 1'b1);
    snap();
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, -1);
    idle(24);
    n_tests++;
    if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL par_err_pulses: got %0d exp 0", vcnt - v0); end
    n_tests++;
    if (PAR_ERR !== 1'b1) begin n_fail++; $display("FAIL par_err_flag: got %b exp 1", PAR_ERR); end
    n_tests++;
    if (STP_ERR !== 1'b0) begin n_fail++; $display("FAIL par_err_stp: got %b exp 0", STP_ERR); end
    n_tests++;
    if (P_DATA !== last_good) begin n_fail++; $display("FAIL par_err_hold: got %h exp %h", P_DATA, last_good); end
  endtask

  task automatic test_stop_err();
    config_rx(16, 1'b0, 1'b0);
    snap();
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, -1);
    idle(48);
    n_tests++;
    if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL stp_err_pulses: got %0d exp 0", vcnt - v0); end
    n_tests++;
    if (stp_cnt - s0 !== 1) begin n_fail++; $display("FAIL stp_err_flag: rises got %0d exp 1", stp_cnt - s0); end
    n_tests++;
    if (P_DATA !== last_good) begin n_fail++; $display("FAIL stp_err_hold: got %h exp %h", P_DATA, last_good); end
    snap();
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b1, -1);
    idle(48);
    last_good = 8'h5A;
    n_tests++;
    if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL stp_recover_pulses: got %0d exp 1", vcnt - v0); end
    n_tests++;
    if (P_DATA !== 8'h5A) begin n_fail++; $display("FAIL stp_recover_data: got %h exp 5a", P_DATA); end
    n_tests++;
    if ({PAR_ERR, STP_ERR} !== 2'b00) begin n_fail++; $display("FAIL stp_recover_flags: got %b exp 00", {PAR_ERR, STP_ERR}); end
  endtask

  task automatic test_start_glitch();
    config_rx(8, 1'b0, 1'b0);
    snap();
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    idle(24);
    n_tests++;
    if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d exp 0", vcnt - v0); end
    n_tests++;
    if ({PAR_ERR, STP_ERR} !== 2'b00) begin n_fail++; $display("FAIL glitch_flags: got %b exp 00", {PAR_ERR, STP_ERR}); end
    // A clean frame right after shows the receiver is back waiting for a start bit.
    snap();
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, -1);
    idle(24);
    last_good = 8'h96;
    n_tests++;
    if (vcnt - v0 !== 1 || P_DATA !== 8'h96) begin
      n_fail++; $display("FAIL glitch_follow: pulses %0d data %h exp 1 / 96", vcnt - v0, P_DATA);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    int k;
    config_rx(16, 1'b0, 1'b0);
    snap();
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1, 3);
    send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b1, -1);
    idle(48);
    last_good = 8'hC3;
    n_tests++;
    if (vcnt - v0 !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d exp 2", vcnt - v0); end
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (vcnt - v0 <= k) begin n_fail++; $display("FAIL b2b_word%0d: got none exp %h", k, e); end
      else if (got_q[v0 + k] !== e) begin n_fail++; $display("FAIL b2b_word%0d: got %h exp %h", k, got_q[v0 + k], e); end
      k++;
    end
  endtask

  task automatic test_reset_mid_frame();
    config_rx(8, 1'b0, 1'b0);
    drive_bit(1'b0, 8, -1);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 8, -1);
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    n_tests++;
    if ({P_DATA, DATA_VALID, PAR_ERR, STP_ERR} !== 11'd0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h/%b%b%b exp 00/000", P_DATA, DATA_VALID, PAR_ERR, STP_ERR);
    end
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    idle(16);
    snap();
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, -1);
    idle(24);
    last_good = 8'h81;
    n_tests++;
    if (vcnt - v0 !== 1 || P_DATA !== 8'h81) begin
      n_fail++; $display("FAIL mid_reset_recover: pulses %0d data %h exp 1 / 81", vcnt - v0, P_DATA);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      int         p, gbit;
      bit         pen, typ, good_par, pbit, sbit, exp_par, exp_stp, exp_valid;
      logic [7:0] d;
      p        = 8 << $urandom_range(0, 2);
      pen      = 1'($urandom_range(0, 1));
      typ      = 1'($urandom_range(0, 1));
      d        = 8'($urandom_range(0, 255));
      good_par = (^d) ^ typ;
      pbit     = ($urandom_range(0, 3) == 0) ? ~good_par : good_par;
      sbit     = ($urandom_range(0, 3) != 0);
      gbit     = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1;
      exp_par   = pen && (pbit != good_par);
      exp_stp   = !sbit;
      exp_valid = !exp_par && !exp_stp;
      if (exp_valid) last_good = d;
      config_rx(p, pen, typ);
      snap();
      send_frame(d, p, pen, pbit, sbit, gbit);
      idle(3 * p);
      n_tests++;
      if (vcnt - v0 !== int'(exp_valid)) begin
        n_fail++; $display("FAIL rnd%0d_pulses: got %0d exp %0d (d=%h p=%0d)", n, vcnt - v0, exp_valid, d, p);
      end
      n_tests++;
      if (par_cnt - p0 !== int'(exp_par)) begin
        n_fail++; $display("FAIL rnd%0d_par: rises got %0d exp %0d", n, par_cnt - p0, exp_par);
      end
      n_tests++;
      if (stp_cnt - s0 !== int'(exp_stp)) begin
        n_fail++; $display("FAIL rnd%0d_stp: rises got %0d exp %0d", n, stp_cnt - s0, exp_stp);
      end
      n_tests++;
      if (P_DATA !== last_good) begin
        n_fail++; $display("FAIL rnd%0d_p_data: got %h exp %h", n, P_DATA, last_good);
      end
    end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_parity_ok();
    test_parity_err();
    test_stop_err();
    test_start_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
